vec_norm_seq: RTL and testbench

//   Normalises an NUM_CH-element unsigned vector so that each output is x_i/sum(x) in Q1.DATAWIDTH fixed point.
//   It is the parametrised successor of the fixed 4-channel (A/B/C/D) arithmetic top, and sits at the same place in the datapath.

---
 rtl/norm_pkg.sv | 13 +
 rtl/seq_restoring_div.sv | 89 ++++++++
 rtl/vec_norm_seq.sv | 143 ++++++++++++++
 tb/tb_vec_norm_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared types and sizing helpers for the vector normaliser.
package norm_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SUM, S_DIV, S_OUT} norm_state_t;

    localparam int DEF_DATAWIDTH = 16;

    // Sum width that cannot overflow for nch channels of dw bits.
    function automatic int sum_width(input int dw, input int nch);
        return dw + $clog2(nch);
    endfunction

endpackage

// File: rtl/seq_restoring_div.sv
// Restoring divider, one quotient bit per cycle; the start cycle already performs the first iteration.
// Precondition: i_num < i_den * 2**Q_W, so the quotient fits Q_W bits and the initial remainder fits DEN_W bits.
module seq_restoring_div #(
    parameter int NUM_W = 32,
    parameter int DEN_W = 18,
    parameter int Q_W   = 17
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [NUM_W-1:0] i_num,
    input  logic [DEN_W-1:0] i_den,
    output logic             o_busy,
    output logic             o_done,
    output logic [Q_W-1:0]   o_q,
    output logic [DEN_W-1:0] o_rem
);

    localparam int CW = $clog2(Q_W + 1);

    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic [DEN_W-1:0] r_rem;
    logic [DEN_W-1:0] r_den;
    logic [Q_W-1:0]   r_q;
    logic [Q_W-1:0]   r_nlo;

    logic [DEN_W-1:0] w_rem_in;
    logic [DEN_W-1:0] w_den;
    logic [Q_W-1:0]   w_nlo_src;
    logic [Q_W-1:0]   w_q_prev;
    logic [DEN_W:0]   w_step;

    function automatic logic [DEN_W:0] div_step(input logic [DEN_W-1:0] rem,
                                                input logic             nbit,
                                                input logic [DEN_W-1:0] den);
        logic [DEN_W:0] trial;
        trial = {rem, nbit};
        if (trial >= {1'b0, den})
            return {1'b1, DEN_W'(trial - {1'b0, den})};
        else
            return {1'b0, trial[DEN_W-1:0]};
    endfunction

    always_comb begin
        w_rem_in  = i_start ? DEN_W'(i_num >> Q_W) : r_rem;
        w_den     = i_start ? i_den : r_den;
        w_nlo_src = i_start ? i_num[Q_W-1:0] : r_nlo;
        w_q_prev  = i_start ? '0 : r_q;
        w_step    = div_step(w_rem_in, w_nlo_src[Q_W-1], w_den);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= CW'(Q_W - 1);
            end else if (r_busy) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    // Datapath registers carry no reset; they are reloaded on every start.
    always_ff @(posedge clk) begin
        if (i_start || r_busy) begin
            r_rem <= w_step[DEN_W-1:0];
            r_den <= w_den;
            r_q   <= {w_q_prev[Q_W-2:0], w_step[DEN_W]};
            r_nlo <= w_nlo_src << 1;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_q    = r_q;
    assign o_rem  = r_rem;

endmodule

// File: rtl/vec_norm_seq.sv
// Normalises an NUM_CH-channel unsigned vector to x_i/sum(x) in Q1.DATAWIDTH using one shared divider.
// Define NORM_ROUND_EN for round-to-nearest (ties up); otherwise results are truncated.
module vec_norm_seq
    import norm_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int NUM_CH    = 4
)(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_valid,
    output logic                              i_ready,
    input  logic [NUM_CH*DATAWIDTH-1:0]       i_data,
    output logic                              o_valid,
    input  logic                              o_ready,
    output logic [NUM_CH*(DATAWIDTH+1)-1:0]   o_data,
    output logic                              o_zero_sum
);

    localparam int SW   = sum_width(DATAWIDTH, NUM_CH);
    localparam int OW   = DATAWIDTH + 1;
    localparam int CH_W = $clog2(NUM_CH);
`ifdef NORM_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    norm_state_t             r_state;
    logic [DATAWIDTH-1:0]    r_x [NUM_CH];
    logic [SW-1:0]           r_sum;
    logic                    r_sum_ok;
    logic [CH_W-1:0]         r_ch;
    logic                    r_valid;
    logic                    r_zero;
    logic [NUM_CH*OW-1:0]    r_data;

    logic [SW-1:0]           w_sum;
    logic [CH_W-1:0]         w_div_ch;
    logic                    w_div_start;
    logic                    w_div_busy;
    logic                    w_div_done;
    logic [OW-1:0]           w_div_q;
    logic [SW-1:0]           w_div_rem;
    logic                    w_round_up;
    logic [OW-1:0]           w_q_fin;
    logic                    w_last_ch;

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_CH; k++)
            w_sum = w_sum + SW'(r_x[k]);
    end

    // The next channel is launched in the same cycle the previous one reports done, so there is no bubble.
    assign w_last_ch   = (r_ch == CH_W'(NUM_CH - 1));
    assign w_div_ch    = (r_state == S_SUM) ? '0 : CH_W'(r_ch + 1'b1);
    assign w_div_start = ((r_state == S_SUM) && r_sum_ok && (r_sum != '0) && !w_div_busy) ||
                         ((r_state == S_DIV) && w_div_done && !w_last_ch);

    seq_restoring_div #(
        .NUM_W (2 * DATAWIDTH),
        .DEN_W (SW),
        .Q_W   (OW)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_div_start),
        .i_num   ({r_x[w_div_ch], {DATAWIDTH{1'b0}}}),
        .i_den   (r_sum),
        .o_busy  (w_div_busy),
        .o_done  (w_div_done),
        .o_q     (w_div_q),
        .o_rem   (w_div_rem)
    );

    assign w_round_up = ROUND_EN && ({w_div_rem, 1'b0} >= {1'b0, r_sum});
    assign w_q_fin    = w_div_q + OW'(w_round_up);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_zero   <= 1'b0;
            r_data   <= '0;
            r_sum_ok <= 1'b0;
            r_ch     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        for (int k = 0; k < NUM_CH; k++)
                            r_x[k] <= i_data[k*DATAWIDTH +: DATAWIDTH];
                        r_data   <= '0;
                        r_zero   <= 1'b0;
                        r_sum_ok <= 1'b0;
                        r_state  <= S_SUM;
                    end
                end
                // First SUM cycle registers the sum; the second decides between divide and zero-sum.
                S_SUM: begin
                    if (!r_sum_ok) begin
                        r_sum    <= w_sum;
                        r_sum_ok <= 1'b1;
                    end else if (r_sum == '0) begin
                        r_zero  <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
                    end else begin
                        r_ch    <= '0;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (w_div_done) begin
                        for (int k = 0; k < NUM_CH; k++)
                            if (r_ch == CH_W'(k))
                                r_data[k*OW +: OW] <= w_q_fin;
                        if (w_last_ch) begin
                            r_valid <= 1'b1;
                            r_state <= S_OUT;
                        end else begin
                            r_ch <= r_ch + 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (o_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i_ready    = (r_state == S_IDLE) && !rst;
    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_zero_sum = r_zero;

endmodule

// File: tb/tb_vec_norm_seq.sv
// Directed bench for vec_norm_seq at DATAWIDTH=16, NUM_CH=4 (both NORM_ROUND_EN builds).
module tb_vec_norm_seq;

    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int OW  = DW + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_valid;
    logic                i_ready;
    logic [NCH*DW-1:0]   i_data;
    logic                o_valid;
    logic                o_ready;
    logic [NCH*OW-1:0]   o_data;
    logic                o_zero_sum;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vec_norm_seq #(.DATAWIDTH(DW), .NUM_CH(NCH)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_zero_sum (o_zero_sum)
    );

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Sends one vector, checks latency, flags and every channel, optionally holds backpressure, then drains it.
    task automatic run_vec(input string tag, input logic [NCH*DW-1:0] din,
                           input logic [NCH*OW-1:0] exp, input int lat,
                           input logic zero, input int hold);
        int cnt;
        bit seen;
        logic [NCH*OW-1:0] snap;
        logic [OW-1:0] a;
        logic [OW-1:0] e;
        chk({tag, "_in_rdy"}, i_ready, 1'b1);
        i_data  = din;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        cnt  = 0;
        seen = 0;
        while (!seen && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (o_valid) seen = 1;
        end
        chk({tag, "_lat"}, cnt, lat);
        chk({tag, "_zero"}, o_zero_sum, zero);
        for (int k = 0; k < NCH; k++) begin
            a = o_data[k*OW +: OW];
            e = exp[k*OW +: OW];
            chk($sformatf("%s_ch%0d", tag, k), a, e);
        end
        snap = o_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_vld"}, o_valid, 1'b1);
            chk({tag, "_hold_rdy"}, i_ready, 1'b0);
            chk({tag, "_hold_data"}, o_data, snap);
        end
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        chk({tag, "_drain_vld"}, o_valid, 1'b0);
        chk({tag, "_drain_rdy"}, i_ready, 1'b1);
    endtask

    logic [NCH*OW-1:0] exp_t1;
    logic [NCH*OW-1:0] exp_t7;
    bit stray;

    initial begin
`ifdef NORM_ROUND_EN
        exp_t1 = {17'h06666, 17'h04CCD, 17'h03333, 17'h0199A};
        exp_t7 = {17'h0AAAB, 17'h00000, 17'h00000, 17'h05555};
`else
        exp_t1 = {17'h06666, 17'h04CCC, 17'h03333, 17'h01999};
        exp_t7 = {17'h0AAAA, 17'h00000, 17'h00000, 17'h05555};
`endif
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        o_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld",  o_valid,    1'b0);
        chk("rst_data", o_data,     '0);
        chk("rst_zero", o_zero_sum, 1'b0);
        chk("rst_rdy",  i_ready,    1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", i_ready, 1'b1);

        run_vec("ramp", {16'h0400, 16'h0300, 16'h0200, 16'h0100}, exp_t1, 70, 1'b0, 0);
        run_vec("flat100", {4{16'h0100}}, {4{17'h04000}}, 70, 1'b0, 0);
        run_vec("flatFFFF", {4{16'hFFFF}}, {4{17'h04000}}, 70, 1'b0, 0);
        run_vec("single0", {16'h0000, 16'h0000, 16'h0000, 16'h1234},
                {17'h0, 17'h0, 17'h0, 17'h10000}, 70, 1'b0, 0);
        run_vec("single3", {16'hFFFF, 16'h0000, 16'h0000, 16'h0000},
                {17'h10000, 17'h0, 17'h0, 17'h0}, 70, 1'b0, 0);
        run_vec("zero", {4{16'h0000}}, '0, 2, 1'b1, 0);
        run_vec("thirds", {16'h0002, 16'h0000, 16'h0000, 16'h0001}, exp_t7, 70, 1'b0, 0);
        run_vec("bp", {16'h0400, 16'h0300, 16'h0200, 16'h0100}, exp_t1, 70, 1'b0, 10);

        // Abort mid-divide: no output may appear, and the next vector must be clean.
        i_data  = {4{16'h0100}};
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_vld",  o_valid, 1'b0);
        chk("abort_data", o_data,  '0);
        chk("abort_rdy",  i_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("abort_rdy_after", i_ready, 1'b1);
        stray = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (o_valid) stray = 1;
        end
        chk("abort_no_output", stray, 1'b0);
        run_vec("after_abort", {16'h0400, 16'h0300, 16'h0200, 16'h0100}, exp_t1, 70, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
